// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: access size codes,
// FSM state encoding and the default data-segment base address.
package dmem_access_unit_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: extracts and extends a load from a DMEM word,
// and merges sub-word store data into the word read back from DMEM.
module dmem_lane_align
    import dmem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_sel,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val  = word[{byte_sel, 3'b000} +: 8];
        half_val  = word[{byte_sel[1], 4'b0000} +: 16];
        load_data = word;
        merged    = word;
        case (size)
            SZ_BYTE: begin
                load_data = is_signed ? {{24{byte_val[7]}}, byte_val} : {24'h0, byte_val};
                merged[{byte_sel, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = is_signed ? {{16{half_val[15]}}, half_val} : {16'h0, half_val};
                merged[{byte_sel[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// CPU data-port to DMEM bridge: validates byte-addressed loads/stores, maps them
// onto word accesses and performs read-modify-write for byte/half stores.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int          DEPTH_WORDS = 2048,
    parameter int          ADDR_W      = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              mem_rena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    state_e      state;
    state_e      state_next;
    logic [31:0] off;
    logic        req_err;
    logic        accept;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign off    = cpu_addr - BASE_ADDR;
    assign accept = (state == ST_IDLE) && cpu_req;

    // Any rejected request goes straight to the response without touching DMEM.
    always_comb begin
        req_err = (off >= LIMIT);
        case (cpu_size)
            SZ_HALF: if (cpu_addr[0])          req_err = 1'b1;
            SZ_WORD: if (cpu_addr[1:0] != 2'b00) req_err = 1'b1;
            SZ_BAD:  req_err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (req_err)
                        state_next = ST_RESP;
                    else if (!cpu_we || cpu_size != SZ_WORD)
                        state_next = ST_READ;
                    else
                        state_next = ST_WRITE;
                end
            end
            ST_READ:  state_next = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Enables decode straight from the state register so reset kills them at once.
    assign mem_rena = (state == ST_READ);
    assign mem_wena = (state == ST_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            signed_q  <= 1'b0;
            lane_q    <= 2'b00;
            wdata_q   <= 32'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            cpu_rdata <= 32'h0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            cpu_ack <= (state_next == ST_RESP);
            cpu_err <= accept && req_err;
            if (accept) begin
                we_q     <= cpu_we;
                size_q   <= cpu_size;
                signed_q <= cpu_signed;
                lane_q   <= off[1:0];
                wdata_q  <= cpu_wdata;
                mem_addr <= off[ADDR_W+1:2];
                if (cpu_we && cpu_size == SZ_WORD)
                    mem_wdata <= cpu_wdata;
                if (req_err && !cpu_we)
                    cpu_rdata <= 32'h0;
            end
            if (state == ST_READ) begin
                if (we_q)
                    mem_wdata <= merged;
                else
                    cpu_rdata <= load_data;
            end
        end
    end

    dmem_lane_align u_lane_align (
        .word      (mem_rdata),
        .byte_sel  (lane_q),
        .size      (size_q),
        .is_signed (signed_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

endmodule
